// File: rtl/data_mem_access.sv
// Memory-access stage: req/ack data-bus transaction with lane steering, load extension and timeout.
// Optional MISALIGNED_SPLIT_EN: word-crossing misaligned accesses run as two bus transactions.
module data_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_value,
  output logic [31:0] mem_load_value,
  output logic        resp_valid,
  output logic        misaligned,
  output logic        bus_err,
  output logic        busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  // Pipeline side: a request transfers when req_valid && req_ready (IDLE only) and a
  // load or store flag is set. Bus side: bus_req and its address/lanes/data stay
  // constant until bus_ack is seen; resp_valid is a single-cycle completion pulse.
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2, BUS_HI = 2'd3} state_t;
  state_t state, state_nxt;

  logic        accept, fault_in, in_bus, hi_phase, final_ack, timeout_hit, split_go;
  logic [31:0] addr_q, wv_q, lane_data, wdata_fmt;
  logic [2:0]  f3_q;
  logic        load_q, fault_q, err_q;
  logic [15:0] cnt_q;
  logic [4:0]  sh;
  logic [3:0]  be_cur;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] v, input logic [1:0] sz);
    case (sz)
      2'b00:   replicate = {4{v[7:0]}};
      2'b01:   replicate = {2{v[15:0]}};
      default: replicate = v;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   extend = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   extend = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  assign accept      = req_valid && req_ready && (is_load || is_store);
  assign in_bus      = (state == BUS) || (state == BUS_HI);
  assign hi_phase    = (state == BUS_HI);
  assign timeout_hit = in_bus && !bus_ack && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign sh          = {addr_q[1:0], 3'b000};

`ifdef MISALIGNED_SPLIT_EN
  logic        split_q, crosses_in;
  logic [31:0] lo_data_q;
  logic [7:0]  lanes;

  assign fault_in   = (funct3[1:0] == 2'b11);
  assign crosses_in = ((funct3[1:0] == 2'b01) && (mem_address[1:0] == 2'b11)) ||
                      ((funct3[1:0] == 2'b10) && (mem_address[1:0] != 2'b00));
  assign split_go   = split_q;
  assign final_ack  = bus_ack && (((state == BUS) && !split_q) || (state == BUS_HI));

  always_comb begin
    lanes  = {4'b0000, size_mask(f3_q[1:0])} << addr_q[1:0];
    be_cur = hi_phase ? lanes[7:4] : lanes[3:0];
    // Misaligned data is rotated so every byte sits on the lane of its own address.
    if (((f3_q[1:0] == 2'b01) && addr_q[0]) || ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)))
      wdata_fmt = 32'(({wv_q, wv_q} << sh) >> 32);
    else
      wdata_fmt = replicate(wv_q, f3_q[1:0]);
    lane_data = 32'({hi_phase ? bus_rdata : 32'h0, hi_phase ? lo_data_q : bus_rdata} >> sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      split_q   <= 1'b0;
      lo_data_q <= 32'h0;
    end else begin
      if (accept) split_q <= crosses_in;
      if ((state == BUS) && bus_ack) lo_data_q <= bus_rdata;
    end
  end
`else
  assign fault_in  = (funct3[1:0] == 2'b11) ||
                     ((funct3[1:0] == 2'b01) && mem_address[0]) ||
                     ((funct3[1:0] == 2'b10) && (mem_address[1:0] != 2'b00));
  assign split_go  = 1'b0;
  assign final_ack = bus_ack && (state == BUS);

  always_comb begin
    be_cur    = size_mask(f3_q[1:0]) << addr_q[1:0];
    wdata_fmt = replicate(wv_q, f3_q[1:0]);
    lane_data = bus_rdata >> sh;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fault_in ? RESP : BUS;
      BUS:     if (bus_ack) state_nxt = split_go ? BUS_HI : RESP;
               else if (timeout_hit) state_nxt = RESP;
      BUS_HI:  if (bus_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    busy       = (state != IDLE);
    resp_valid = (state == RESP);
    misaligned = resp_valid && fault_q;
    bus_err    = resp_valid && err_q;
    bus_req    = in_bus;
    bus_we     = in_bus && !load_q;
    bus_addr   = in_bus ? ({addr_q[31:2], 2'b00} + (hi_phase ? 32'd4 : 32'd0)) : 32'h0;
    bus_be     = in_bus ? be_cur : 4'b0000;
    bus_wdata  = in_bus ? wdata_fmt : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= 32'h0;
      wv_q           <= 32'h0;
      f3_q           <= 3'b000;
      load_q         <= 1'b0;
      fault_q        <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= 16'h0;
      mem_load_value <= 32'h0;
    end else begin
      if (accept) begin
        addr_q  <= mem_address;
        wv_q    <= mem_write_value;
        f3_q    <= funct3;
        load_q  <= is_load;
        fault_q <= fault_in;
        err_q   <= 1'b0;
      end
      if (timeout_hit) err_q <= 1'b1;
      // Counter restarts on every ack so each half of a split access gets its own budget.
      cnt_q <= (in_bus && !bus_ack) ? cnt_q + 16'd1 : 16'd0;
      if (final_ack && load_q) mem_load_value <= extend(lane_data, f3_q);
    end
  end
endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: directed scenarios then randomized accesses
// against a byte-level reference model. Honours MISALIGNED_SPLIT_EN when defined.
module tb_data_mem_access;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] mem_address, mem_write_value, mem_load_value;
  logic        resp_valid, misaligned, bus_err, busy, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_lv;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  data_mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .mem_address(mem_address), .mem_write_value(mem_write_value),
    .mem_load_value(mem_load_value), .resp_valid(resp_valid),
    .misaligned(misaligned), .bus_err(bus_err), .busy(busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_fault(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b11) return 1'b1;
`ifdef MISALIGNED_SPLIT_EN
    return 1'b0;
`else
    return (int'(a[1:0]) % nbytes(f3[1:0])) != 0;
`endif
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input int n, input int b);
    logic [3:0] be;
    be = '0;
    for (int j = 0; j < 4; j++) begin
      int d;
      d = j + 4 * b - int'(a[1:0]);
      if (d >= 0 && d < n) be[j] = 1'b1;
    end
    return be;
  endfunction

  // Lane j carries the write byte whose address maps onto it; aligned small accesses repeat.
  function automatic logic [31:0] exp_wdata(input logic [31:0] wv, input logic [31:0] a, input int n);
    logic [31:0] w;
    bit aligned;
    aligned = (int'(a[1:0]) % n) == 0;
    for (int j = 0; j < 4; j++) begin
      int d, idx;
      d = j - int'(a[1:0]);
      idx = aligned ? (((d % n) + n) % n) : (((d % 4) + 4) % 4);
      w[8*j +: 8] = wv[8*idx +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd0, input logic [31:0] rd1,
                                           input logic [31:0] a, input logic [2:0] f3);
    logic [63:0] r;
    logic [31:0] v;
    int n;
    r = {rd1, rd0};
    v = '0;
    n = nbytes(f3[1:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = r[8*(int'(a[1:0]) + i) +: 8];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_access(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wv,
                           input logic [31:0] rd0, input logic [31:0] rd1,
                           input int dly0, input int dly1);
    bit flt, tmo;
    int n, beats;
    flt   = is_fault(f3, a);
    n     = nbytes(f3[1:0]);
    beats = (int'(a[1:0]) + n > 4) ? 2 : 1;
    @(negedge clk);
    check("idle_req_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    mem_address = a; mem_write_value = wv;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0; is_load = 1'($urandom); is_store = 1'($urandom);
    mem_address = $urandom; mem_write_value = $urandom; bus_ack = 1'b0;
    tmo = 1'b0;
    if (!flt) begin
      for (int b = 0; b < beats && !tmo; b++) begin
        int dly;
        dly = (b == 0) ? dly0 : dly1;
        for (int k = 0; k < 100; k++) begin
          if (k == TMO) begin
            tmo = 1'b1;
            break;
          end
          check("bus_req_held", {31'h0, bus_req}, 32'h1);
          check("bus_addr", bus_addr, {a[31:2], 2'b00} + 32'(4 * b));
          check("bus_be", {28'h0, bus_be}, {28'h0, exp_be(a, n, b)});
          check("bus_we", {31'h0, bus_we}, {31'h0, !ld});
          if (!ld) check("bus_wdata", bus_wdata, exp_wdata(wv, a, n));
          check("busy_in_bus", {31'h0, busy}, 32'h1);
          check("req_ready_in_bus", {31'h0, req_ready}, 32'h0);
          check("no_resp_in_bus", {31'h0, resp_valid}, 32'h0);
          if (k == dly) begin
            bus_ack = 1'b1;
            bus_rdata = (b == 0) ? rd0 : rd1;
            @(negedge clk);
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            break;
          end
          @(negedge clk);
        end
      end
    end
    // response cycle
    if (ld && !flt && !tmo) model_lv = exp_load(rd0, rd1, a, f3);
    exp_q.push_back(model_lv);
    check("resp_valid", {31'h0, resp_valid}, 32'h1);
    check("resp_misaligned", {31'h0, misaligned}, {31'h0, flt});
    check("resp_bus_err", {31'h0, bus_err}, {31'h0, tmo});
    check("resp_bus_req_low", {31'h0, bus_req}, 32'h0);
    check("resp_busy", {31'h0, busy}, 32'h1);
    check("resp_load_value", mem_load_value, exp_q.pop_front());
    @(negedge clk);
    bus_ack = 1'($urandom_range(0, 1));
    check("post_resp_pulse_end", {31'h0, resp_valid}, 32'h0);
    check("post_resp_ready", {31'h0, req_ready}, 32'h1);
    check("post_resp_busy", {31'h0, busy}, 32'h0);
    check("load_value_hold", mem_load_value, model_lv);
  endtask

  task automatic no_accept();
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b0; is_store = 1'b0; funct3 = 3'($urandom);
    mem_address = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    check("noflag_busy", {31'h0, busy}, 32'h0);
    check("noflag_bus_req", {31'h0, bus_req}, 32'h0);
    check("noflag_resp", {31'h0, resp_valid}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    mem_address = 32'h0; mem_write_value = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    model_lv = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_load_value", mem_load_value, 32'h0);
    check("rst_bus_be", {28'h0, bus_be}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'h0, req_ready}, 32'h1);

    // load byte signed at lane 3
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, $urandom, 32'h80AA_BBCC, 32'h0, 2, 0);
    check("lb_signed_value", mem_load_value, 32'hFFFF_FF80);
    // store half, upper lanes; load value must survive
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, $urandom, $urandom, 1, 0);
    check("sh_keeps_load_value", mem_load_value, 32'hFFFF_FF80);
    // misaligned word load
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_3001, $urandom, 32'h4433_2211, 32'h8877_6655, 1, 2);
`ifdef MISALIGNED_SPLIT_EN
    check("lw_split_value", mem_load_value, 32'h5544_3322);
`else
    check("lw_fault_value", mem_load_value, 32'hFFFF_FF80);
`endif
    // never acked -> timeout; then ack exactly at the limit
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_4000, $urandom, $urandom, $urandom, 50, 50);
    do_access(1'b1, 1'b0, 3'b110, 32'h0000_4000, $urandom, 32'hCAFE_F00D, $urandom, TMO - 1, 0);
    check("ack_at_limit_value", mem_load_value, 32'hCAFE_F00D);
    // size 11 faults
    do_access(1'b0, 1'b1, 3'b011, 32'h0000_5000, $urandom, $urandom, $urandom, 0, 0);
    // load+store flags together behave as load
    do_access(1'b1, 1'b1, 3'b101, 32'h0000_6002, $urandom, 32'h8001_1234, $urandom, 0, 0);
    check("both_flags_lhu", mem_load_value, 32'h0000_8001);
    no_accept();

    // reset while bus_req is high
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; mem_address = 32'h0000_7000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_bus_req_before", {31'h0, bus_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bus_req_dropped", {31'h0, bus_req}, 32'h0);
    check("midrst_no_resp", {31'h0, resp_valid}, 32'h0);
    rst = 1'b0;
    model_lv = 32'h0;
    @(negedge clk);
    check("midrst_ready_after", {31'h0, req_ready}, 32'h1);
    check("midrst_no_resp_after", {31'h0, resp_valid}, 32'h0);
    check("midrst_load_value", mem_load_value, 32'h0);

    // randomized accesses
    for (int t = 0; t < 200; t++) begin
      int kind;
      kind = $urandom_range(0, 7);
      if (kind == 0) no_accept();
      else
        do_access(kind != 2 && kind != 3, kind >= 2 && kind <= 4, 3'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
